// File: rtl/pool2_stream.sv
// Streaming 3x3 / stride-2 max-pool over a raster-ordered IN_DIM x IN_DIM plane.
// The datapath folds each window in two steps: a horizontal running max along the row, then a vertical partial max per output column.
module pool2_stream #(
    parameter int DATA_W = 16,
    parameter int IN_DIM = 27,
    parameter int WIN    = 3,
    parameter int STRIDE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
);
    localparam int OUT_DIM = (IN_DIM - WIN) / STRIDE + 1;
    localparam int CW      = $clog2(IN_DIM);
    localparam int OW      = $clog2(OUT_DIM);

    function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0]                    row_q, row_d, col_q, col_d;
    logic [DATA_W-1:0]                hmax_q, hmax_d;
    logic [OUT_DIM-1:0][DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]                out_q, out_d;
    logic                             vld_q, vld_d, last_q, last_d;
    logic                             accept;
    logic [DATA_W-1:0]                hv;
    logic [OW-1:0]                    widx;

    assign in_ready  = !vld_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_q;
    assign out_data  = out_q;
    assign out_last  = last_q;

    // hv: full 3-wide horizontal max, meaningful when the current pixel closes a window (even col >= 2)
    assign hv   = umax(hmax_q, in_data);
    assign widx = OW'(col_q >> 1) - OW'(1);

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        hmax_d = hmax_q;
        acc_d  = acc_q;
        out_d  = out_q;
        vld_d  = vld_q;
        last_d = last_q;
        if (vld_q && out_ready) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
        if (accept) begin
            if (col_q == CW'(IN_DIM - 1)) begin
                col_d = '0;
                row_d = (row_q == CW'(IN_DIM - 1)) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (col_q == '0) begin
                hmax_d = in_data;
            end else if (col_q[0]) begin
                hmax_d = hv;
            end else begin
                // Shared even column: closes window widx and opens the next one
                hmax_d = in_data;
                if (row_q == '0) begin
                    acc_d[widx] = hv;
                end else if (row_q[0]) begin
                    acc_d[widx] = umax(acc_q[widx], hv);
                end else begin
                    // Shared even row: emit the finished window, seed the next window row
                    acc_d[widx] = hv;
                    out_d       = umax(acc_q[widx], hv);
                    vld_d       = 1'b1;
                    last_d      = (row_q == CW'(IN_DIM - 1)) && (col_q == CW'(IN_DIM - 1));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            hmax_q <= '0;
            acc_q  <= '0;
            out_q  <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            hmax_q <= hmax_d;
            acc_q  <= acc_d;
            out_q  <= out_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end
endmodule

// File: tb/tb_pool2_stream.sv
// Self-checking bench for pool2_stream: table of whole-frame vectors, random frames against a window-max model, and handshake/reset corner sequences.
module tb_pool2_stream;
    localparam int DW = 16, N = 27, M = 13, NP = N * N, NO = M * M;

    logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, out_last;
    logic [DW-1:0] out_data;

    int checks = 0, failures = 0;
    logic [DW-1:0] frm  [NP];
    logic [DW-1:0] expv [NO];
    logic [DW-1:0] got_d [$];
    bit            got_l [$];

    pool2_stream dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Inputs change on negedge; a transfer is logged once the handshake is settled before the next posedge.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    task automatic model();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                int m = 0;
                for (int dy = 0; dy < 3; dy++)
                    for (int dx = 0; dx < 3; dx++)
                        if (int'(frm[(2*r+dy)*N + 2*c+dx]) > m) m = int'(frm[(2*r+dy)*N + 2*c+dx]);
                expv[r*M+c] = DW'(m);
            end
    endtask

    task automatic fill_ramp(input int off);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) frm[i*N+j] = DW'(N*i + j + off);
    endtask

    task automatic cycle_drive(input bit v, input logic [DW-1:0] d, input bit rr);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        if (rr) out_ready = ($urandom_range(0, 99) < 70);
    endtask

    task automatic send_px(input logic [DW-1:0] v, input int vpct, input bit rr);
        int w;
        while (vpct < 100 && $urandom_range(0, 99) >= vpct) cycle_drive(1'b0, '0, rr);
        for (w = 0; w < 300; w++) begin
            cycle_drive(1'b1, v, rr);
            #1;
            if (in_ready) break;
        end
        if (w == 300) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic send_frame(input int vpct, input bit rr);
        for (int i = 0; i < NP; i++) send_px(frm[i], vpct, rr);
    endtask

    task automatic wait_results(input int n, input bit rr);
        for (int k = 0; k < 5000 && got_d.size() < n; k++) cycle_drive(1'b0, '0, rr);
        out_ready = 1'b1;
        repeat (6) cycle_drive(1'b0, '0, 1'b0);
        chk("result_count", got_d.size(), n);
    endtask

    task automatic check_frame(input string nm, input int base);
        int bad = -1;
        if (got_d.size() < base + NO) bad = NO;
        else
            for (int k = NO - 1; k >= 0; k--)
                if (got_d[base+k] !== expv[k] || got_l[base+k] !== (k == NO - 1)) bad = k;
        checks++;
        if (bad >= 0) begin
            failures++;
            if (bad == NO) $display("FAIL %s: only %0d results, needed %0d", nm, got_d.size(), base + NO);
            else $display("FAIL %s: out[%0d] got data=%0d last=%0d expected data=%0d last=%0d", nm, bad,
                          got_d[base+bad], got_l[base+bad], expv[bad], bad == NO - 1);
        end
    endtask

    typedef struct {
        string         nm;
        bit            ramp;
        bit            stress;
        logic [DW-1:0] base;
        int            pr, pc;
        logic [DW-1:0] pv;
        int            i0;
        logic [DW-1:0] e0;
        int            i1;
        logic [DW-1:0] e1;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{"ramp",    1'b1, 1'b0, 16'h0000, -1, -1, 16'h0000, 0,  16'd56,   168, 16'd728};
        tbl[1] = '{"peak",    1'b0, 1'b0, 16'h0000, 14, 14, 16'h8000, 84, 16'h8000, 83,  16'h0000};
        tbl[2] = '{"peak_b",  1'b0, 1'b0, 16'h0000, 14, 14, 16'h8000, 98, 16'h8000, 99,  16'h0000};
        tbl[3] = '{"sat",     1'b0, 1'b0, 16'hFFFF, 10, 10, 16'h0001, 0,  16'hFFFF, 168, 16'hFFFF};
        tbl[4] = '{"unsign",  1'b0, 1'b0, 16'h7FFF, 0,  0,  16'h8000, 0,  16'h8000, 1,   16'h7FFF};
        tbl[5] = '{"ramp_hs", 1'b1, 1'b1, 16'h0000, -1, -1, 16'h0000, 0,  16'd56,   168, 16'd728};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[t]) begin
            got_d.delete(); got_l.delete();
            if (tbl[t].ramp) fill_ramp(0);
            else begin
                foreach (frm[i]) frm[i] = tbl[t].base;
                frm[tbl[t].pr*N + tbl[t].pc] = tbl[t].pv;
            end
            model();
            send_frame(tbl[t].stress ? 60 : 100, tbl[t].stress);
            wait_results(NO, tbl[t].stress);
            if (got_d.size() == NO) begin
                chk({tbl[t].nm, "_e0"}, got_d[tbl[t].i0], tbl[t].e0);
                chk({tbl[t].nm, "_e1"}, got_d[tbl[t].i1], tbl[t].e1);
            end
            check_frame({tbl[t].nm, "_model"}, 0);
        end

        for (int f = 0; f < 2; f++) begin
            got_d.delete(); got_l.delete();
            foreach (frm[i]) frm[i] = DW'($urandom_range(0, 65535));
            model();
            send_frame(75, 1'b1);
            wait_results(NO, 1'b1);
            check_frame("random_model", 0);
        end

        // Backpressure right after the first result appears
        got_d.delete(); got_l.delete();
        fill_ramp(0); model();
        out_ready = 1'b1;
        fork
            send_frame(100, 1'b0);
            begin
                int k, bad;
                for (k = 0; k < 2000; k++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                chk("bp_first_seen", k < 2000, 1);
                out_ready = 1'b0;
                #1;
                chk("bp_in_ready_fall", in_ready, 0);
                chk("bp_first_data", out_data, 56);
                bad = 0;
                repeat (10) begin
                    @(negedge clk);
                    #1;
                    if (!out_valid || out_data !== 16'd56 || in_ready || out_last) bad++;
                end
                chk("bp_hold", bad, 0);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_results(NO, 1'b0);
        check_frame("bp_model", 0);

        // Reset mid-frame, then a clean ramp frame
        fill_ramp(0); model();
        for (int i = 0; i < 400; i++) send_px(frm[i], 100, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        chk("midrst_out_valid_hold", out_valid, 0);
        rst_n = 1'b1;
        got_d.delete(); got_l.delete();
        send_frame(100, 1'b0);
        wait_results(NO, 1'b0);
        check_frame("midrst_model", 0);

        // Back-to-back frames, second offset by 1000
        got_d.delete(); got_l.delete();
        fill_ramp(0);
        send_frame(100, 1'b0);
        fill_ramp(1000);
        send_frame(100, 1'b0);
        wait_results(2 * NO, 1'b0);
        model();
        check_frame("b2b_second", NO);
        if (got_d.size() > NO) chk("b2b_second_first", got_d[NO], 1056);
        begin
            int nl = 0;
            foreach (got_l[i]) nl += got_l[i];
            chk("b2b_last_count", nl, 2);
        end
        fill_ramp(0); model();
        check_frame("b2b_first", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pool2_stream.md
# pool2_stream

Streaming 3x3, stride-2 max-pool that consumes the 27x27 single-channel feature map produced by the second convolution layer and emits the 13x13 pooled map. Input pixels arrive one per cycle in raster order over a valid/ready handshake. Pooled results leave in raster order over a second valid/ready handshake, with an end-of-frame marker. The block is the downstream reader of the conv2 output plane and feeds the 13x13 stage.

## Interface
Parameters:
- DATA_W, 16, pixel width; unsigned.
- IN_DIM, 27, input height and width.
- WIN, 3, pooling window edge.
- STRIDE, 2, window step.
- OUT_DIM, (IN_DIM-WIN)/STRIDE+1 = 13, derived; not overridden.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a valid pixel.
- in_data  in  DATA_W  input pixel, raster order (row-major, column fastest).
- in_ready  out  1  block accepts a pixel this cycle.
- out_valid  out  1  out_data holds a pooled result.
- out_data  out  DATA_W  pooled maximum.
- out_last  out  1  high with the final result (13th row, 13th column) of a frame.
- out_ready  in  1  downstream accepts the result this cycle.

## Operation
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Input counters: in_row and in_col, both 0..IN_DIM-1.
  - in_col increments on every accept.
  - At in_col = IN_DIM-1, in_col wraps to 0 and in_row increments.
  - At (IN_DIM-1, IN_DIM-1), both wrap to 0. The next frame starts with no gap.
- Output (r,c) = unsigned max of input pixels at rows 2r..2r+2, columns 2c..2c+2.
  - Edge pixels (even row or even column, except 0 and 26) belong to two windows per axis and contribute to both.
- Completion: window (r,c) completes on accept of pixel (2r+2, 2c+2).
  - No output is produced while in_row < 2.
  - No output is produced on odd in_col, or on even in_col < 2.
- Storage:
  - Partial maxima for up to two overlapping window rows, OUT_DIM entries each.
  - A horizontal running max for the current row.
  - Comparisons are DATA_W-bit unsigned; no widening or truncation.
- Output register: one entry.
  - Loaded on the completing accept.
  - Held stable (data and last) until transferred.
- Backpressure: in_ready = !out_valid || out_ready.
  - Simultaneous transfer of the old result and load of a new one in the same cycle is legal. out_valid stays high.
- out_last = 1 only for output (OUT_DIM-1, OUT_DIM-1).
- Pixels with in_valid high and in_ready low are not consumed. The source holds them.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_last=0, out_data=0, counters=0, partial maxima cleared.
  - in_ready is 1 while reset is asserted and after release.
- Reset mid-frame discards the partial frame. The next accepted pixel is treated as (0,0).
- Latency: out_valid rises the cycle after the completing accept.
- Throughput: 1 pixel/cycle when out_ready is held high. A frame takes 729 accept cycles and yields 169 results.
- After a non-completing accept with no pending output, out_valid = 0 on the next cycle.
- No combinational path from in_valid to in_ready. out_ready to in_ready is combinational.

## Test plan
- Ramp: pixel(i,j) = 27i+j, out_ready=1.
  - Expect out(r,c) = 27(2r+2)+2c+2, e.g. out[0]=56 and out[168]=728.
  - out_last is high only on out[168]. Exactly 169 results.
- Single peak: 0x8000 at (14,14), all else 0.
  - Outputs (6,6), (6,7), (7,6), (7,7) = 0x8000; all others 0.
- Saturation/unsigned: all pixels 0xFFFF except one 0x0001 → every output 0xFFFF.
  - Repeat with 0x7FFF everywhere and 0x8000 at (0,0): out(0,0)=0x8000, proving an unsigned compare.
- Backpressure: ramp frame; drop out_ready for 10 cycles right after out[0] appears.
  - in_ready falls within the same cycle and stays low.
  - out_data=56 is held stable. No pixels are lost; the sequence resumes intact.
- Reset mid-frame: assert rst_n low after 400 pixels, then stream a full ramp frame.
  - Outputs match the ramp expectations exactly.
  - out_valid = 0 during reset.
- Back-to-back frames: two ramp frames with no idle cycle, the second offset by +1000.
  - Second-frame out[0] = 1056.
  - out_last fires once per frame.
